// File: rtl/wam_mole_ctl.sv
// Whack-a-mole mole controller. Conditions the eight player buttons,
// raises one mole LED at a time at pseudo-random lanes, and reports
// single-cycle hit / miss pulses to the downstream score counter.
module wam_mole_ctl #(
  parameter int unsigned DEBOUNCE  = 250000,
  parameter int unsigned MOLE_TIME = 75000000,
  parameter int unsigned GAP_TIME  = 25000000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] btn,
  output logic [7:0] mole,
  output logic [7:0] hit,
  output logic       miss,
  output logic [2:0] lane
);

  // Counter only needs to hold DEBOUNCE-1: the flip happens on the edge it would reach DEBOUNCE.
  localparam int unsigned   CW        = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [31:0]   GAP_LOAD  = 32'(GAP_TIME - 1);
  localparam logic [31:0]   MOLE_LOAD = 32'(MOLE_TIME - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_UP   = 2'd2
  } state_t;

  // Feedback bit for x^8+x^6+x^5+x^4+1 with a left-shifting register.
  function automatic logic lfsr_fb(input logic [7:0] s);
    return s[7] ^ s[5] ^ s[4] ^ s[3];
  endfunction

  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [7:0]    db_q, db_d;
  logic [7:0]    db_dly_q, db_dly_d;
  logic [CW-1:0] cnt_q [8];
  logic [CW-1:0] cnt_d [8];
  logic [7:0]    press_evt;

  logic [7:0]    lfsr_q, lfsr_d;
  state_t        state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic [7:0]    mole_q, mole_d;
  logic [7:0]    hit_q, hit_d;
  logic          miss_q, miss_d;
  logic [2:0]    lane_q, lane_d;
  logic [2:0]    cand;

  // Synchronise and debounce each lane; the debounced level only moves after a stable run.
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_dly_d = db_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // A press is a one-cycle rising edge of the debounced level; releases are dropped.
  assign press_evt = db_q & ~db_dly_q;

  // Free-running pseudo-random source, independent of en.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_fb(lfsr_q)};
  end

  // Next lane: LFSR low bits, nudged by one so the same lane never comes up twice in a row.
  always_comb begin
    cand = lfsr_q[2:0];
    if (lfsr_q[2:0] == lane_q) begin
      cand = lfsr_q[2:0] + 3'd1;
    end else begin
      cand = lfsr_q[2:0];
    end
  end

  // Game sequencing; a hit wins over a simultaneous timeout so miss never pairs with hit.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mole_d  = mole_q;
    lane_d  = lane_q;
    hit_d   = 8'h00;
    miss_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      mole_d  = 8'h00;
      timer_d = 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
          mole_d  = 8'h00;
        end
        ST_GAP: begin
          if (timer_q == 32'd0) begin
            state_d = ST_UP;
            lane_d  = cand;
            mole_d  = 8'd1 << cand;
            timer_d = MOLE_LOAD;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        ST_UP: begin
          if (press_evt[lane_q]) begin
            hit_d   = 8'd1 << lane_q;
            mole_d  = 8'h00;
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end else if (timer_q == 32'd0) begin
            miss_d  = 1'b1;
            mole_d  = 8'h00;
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          mole_d  = 8'h00;
          timer_d = 32'd0;
        end
      endcase
    end
  end

  // All state and outputs registered; clr returns everything to its idle values.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q  <= 8'h00;
      sync2_q  <= 8'h00;
      db_q     <= 8'h00;
      db_dly_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      lfsr_q   <= LFSR_SEED;
      state_q  <= ST_IDLE;
      timer_q  <= 32'd0;
      mole_q   <= 8'h00;
      hit_q    <= 8'h00;
      miss_q   <= 1'b0;
      lane_q   <= 3'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      lfsr_q   <= lfsr_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      mole_q   <= mole_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      lane_q   <= lane_d;
    end
  end

  assign mole = mole_q;
  assign hit  = hit_q;
  assign miss = miss_q;
  assign lane = lane_q;

endmodule

// File: tb/tb_wam_mole_ctl.sv
// Scoreboard bench for wam_mole_ctl: stimulus pushes expected output events
// (edge, kind, value, lane); a monitor pops and compares every output change.
module tb_wam_mole_ctl;

  localparam int         DB   = 4;
  localparam int         MT   = 20;
  localparam int         GT   = 5;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int K_MOLE = 0;
  localparam int K_HIT  = 1;
  localparam int K_MISS = 2;

  typedef struct {
    int         kind;
    int         edge_no;
    logic [7:0] val;
    logic [2:0] ln;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [7:0] btn;
  logic [7:0] mole;
  logic [7:0] hit;
  logic       miss;
  logic [2:0] lane;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         edge_n = 0;
  logic [7:0] m_lfsr = SEED;
  logic [2:0] model_lane = 3'd0;
  logic       mon_on = 1'b0;
  logic [7:0] prev_mole = 8'h00;
  logic       have_rise = 1'b0;
  logic [2:0] last_rise_lane = 3'd0;
  int         rise = 0;

  wam_mole_ctl #(
    .DEBOUNCE (DB),
    .MOLE_TIME(MT),
    .GAP_TIME (GT),
    .LFSR_SEED(SEED)
  ) dut (
    .clk (clk),
    .clr (clr),
    .en  (en),
    .btn (btn),
    .mole(mole),
    .hit (hit),
    .miss(miss),
    .lane(lane)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Edge counter: between edge k and k+1 edge_n reads k.
  always @(posedge clk) edge_n <= edge_n + 1;

  // Reference LFSR stepping alongside the design.
  always @(posedge clk) m_lfsr <= clr ? SEED : lfsr_step(m_lfsr);

  // Lane chosen for a mole rising at edge r (uses LFSR value just before edge r).
  function automatic logic [2:0] next_lane(input int r);
    logic [7:0] l;
    logic [2:0] c;
    l = m_lfsr;
    for (int i = 0; i < r - 1 - edge_n; i++) l = lfsr_step(l);
    c = l[2:0];
    if (c == model_lane) c = c + 3'd1;
    return c;
  endfunction

  task automatic push(input int kind, input int e, input logic [7:0] v,
                      input logic [2:0] l, input string nm);
    exp_t x;
    x.kind = kind; x.edge_no = e; x.val = v; x.ln = l; x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic predict_mole(input int r, input string nm);
    model_lane = next_lane(r);
    push(K_MOLE, r, 8'd1 << model_lane, model_lane, nm);
  endtask

  task automatic go_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic observe(input int kind, input logic [7:0] v);
    exp_t x;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: kind=%0d val=%h lane=%0d at edge %0d, nothing expected",
               kind, v, lane, edge_n);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != kind || x.edge_no != edge_n || x.val !== v || x.ln !== lane) begin
        n_errors++;
        $display("FAIL %s: got kind=%0d val=%h lane=%0d edge=%0d, expected kind=%0d val=%h lane=%0d edge=%0d",
                 x.name, kind, v, lane, edge_n, x.kind, x.val, x.ln, x.edge_no);
      end
    end
  endtask

  // Monitor: every output change is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (mole !== prev_mole) begin
          observe(K_MOLE, mole);
          if (mole != 8'h00) begin
            n_checks++;
            if (have_rise && lane == last_rise_lane) begin
              n_errors++;
              $display("FAIL lane_repeat: lane %0d equals previous mole lane %0d at edge %0d",
                       lane, last_rise_lane, edge_n);
            end
            have_rise = 1'b1;
            last_rise_lane = lane;
          end
        end
        if (hit !== 8'h00) observe(K_HIT, hit);
        if (miss !== 1'b0) observe(K_MISS, 8'h01);
        prev_mole = mole;
      end
    end
  end

  // Clean (or multi-lane) press on the current mole sampled at edge s.
  task automatic press_hit(input int s, input logic [7:0] extra, input string nm);
    int he;
    go_to(s - 1);
    btn = extra | (8'd1 << model_lane);
    he = s + DB + 2;
    push(K_MOLE, he, 8'h00, model_lane, {nm, "_mole_fall"});
    push(K_HIT, he, 8'd1 << model_lane, model_lane, nm);
    rise = he + GT;
    predict_mole(rise, {nm, "_next_mole"});
    go_to(s + 6);
    btn = 8'h00;
  endtask

  initial begin
    int         p;
    int         r2;
    logic [2:0] lr;
    logic [2:0] w;

    // 1. Reset with buttons and en asserted.
    clr = 1'b1; en = 1'b1; btn = 8'hFF;
    go_to(2);
    chk("reset_mole", mole, 8'h00);
    chk("reset_hit", hit, 8'h00);
    chk("reset_miss", {7'd0, miss}, 8'h00);
    chk("reset_lane", {5'd0, lane}, 8'h00);
    clr = 1'b0; btn = 8'h00; mon_on = 1'b1;
    rise = 8;
    predict_mole(rise, "first_mole");

    // 2. Clean hit, then a hit with every button pressed together.
    press_hit(rise + 1, 8'h00, "hit_clean");
    press_hit(rise + 3, 8'hFF, "hit_all_buttons");

    // 3. Wrong-lane press leads to a miss.
    p = rise;
    lr = next_lane(p + MT + GT);
    w = model_lane + 3'd1;
    while (w == lr || w == model_lane) w = w + 3'd1;
    go_to(p);
    btn = 8'd1 << w;
    push(K_MOLE, p + MT, 8'h00, model_lane, "miss_mole_fall");
    push(K_MISS, p + MT, 8'h01, model_lane, "miss_pulse");
    rise = p + MT + GT;
    predict_mole(rise, "after_miss_mole");
    go_to(p + 7);
    btn = 8'h00;

    // 4. Bounce for 20 cycles, then a long hold: one hit only.
    for (int k = 0; k < 10; k++) begin
      go_to(rise - 15 + 2 * k);
      btn = (k % 2 == 0) ? (8'd1 << model_lane) : 8'h00;
    end
    go_to(rise + 5);
    btn = 8'd1 << model_lane;
    push(K_MOLE, rise + 12, 8'h00, model_lane, "bounce_mole_fall");
    push(K_HIT, rise + 12, 8'd1 << model_lane, model_lane, "bounce_hit");
    p = rise;
    r2 = p + 12 + GT;
    predict_mole(r2, "after_bounce_mole");
    push(K_MOLE, r2 + MT, 8'h00, model_lane, "held_mole_fall");
    push(K_MISS, r2 + MT, 8'h01, model_lane, "held_miss");
    rise = r2 + MT + GT;
    predict_mole(rise, "collision_mole");
    go_to(p + 32);
    btn = 8'h00;

    // 5. Correct press landing on the timeout edge counts as a hit.
    go_to(rise + MT - DB - 3);
    btn = 8'd1 << model_lane;
    push(K_MOLE, rise + MT, 8'h00, model_lane, "collision_mole_fall");
    push(K_HIT, rise + MT, 8'd1 << model_lane, model_lane, "collision_hit");
    p = rise + MT;
    rise = p + GT;
    predict_mole(rise, "run_mole_0");
    go_to(p);
    btn = 8'h00;
    for (int i = 0; i < 50; i++) begin
      push(K_MOLE, rise + MT, 8'h00, model_lane, "run_mole_fall");
      push(K_MISS, rise + MT, 8'h01, model_lane, "run_miss");
      rise = rise + MT + GT;
      predict_mole(rise, "run_mole");
    end

    // 6. Disable mid-UP, press while idle, then re-enable.
    go_to(rise + 3);
    en = 1'b0;
    push(K_MOLE, rise + 4, 8'h00, model_lane, "disable_mole_fall");
    go_to(rise + 6);
    btn = 8'hFF;
    go_to(rise + 16);
    btn = 8'h00;
    go_to(rise + 30);
    en = 1'b1;
    r2 = rise + 36;
    predict_mole(r2, "reenable_mole");
    push(K_MOLE, r2 + MT, 8'h00, model_lane, "reenable_mole_fall");
    push(K_MISS, r2 + MT, 8'h01, model_lane, "reenable_miss");
    go_to(r2 + MT + 4);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_events: %0d expected events never seen, first %s at edge %0d",
               exp_q.size(), exp_q[0].name, exp_q[0].edge_no);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the run never reaches its end.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

endmodule
